// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Holds the frame-parser state encoding and the default frame start marker.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } loader_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Running XOR checksum over payload bytes
    function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] data);
        return csum ^ data;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Framed byte stream to 32-bit instruction writer: SYNC, LEN_LO, LEN_HI, N*4 payload
// bytes (LSB first), XOR checksum. Emits one write pulse per word, then a done pulse.
module program_loader
    import loader_pkg::*;
#(
    parameter int         INST_MEM_ADDR_SIZE = 10,
    parameter logic [7:0] SYNC_BYTE          = SYNC_BYTE_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic                          rx_ready,
    output logic [31:0]                   inst,
    output logic [INST_MEM_ADDR_SIZE-1:0] inst_mem_offset,
    output logic                          programming_data_valid,
    output logic                          programming_done,
    output logic                          load_error
);

    // One extra bit so a full-memory frame counts to 2**INST_MEM_ADDR_SIZE without wrapping
    localparam int IDX_W = INST_MEM_ADDR_SIZE + 1;

    loader_state_e                   state_r, state_nxt_s;
    logic [15:0]                     len_r, len_nxt_s, len_full_s;
    logic [31:0]                     word_r, word_nxt_s;
    logic [1:0]                      byte_cnt_r, byte_cnt_nxt_s;
    logic [IDX_W-1:0]                word_idx_r, word_idx_nxt_s;
    logic [7:0]                      csum_r, csum_nxt_s;
    logic [31:0]                     inst_nxt_s;
    logic [INST_MEM_ADDR_SIZE-1:0]   offset_nxt_s;
    logic                            dv_nxt_s, done_nxt_s, err_nxt_s, ready_nxt_s;
    logic                            accept_s, len_too_big_s, last_word_s;

    assign accept_s      = rx_valid & rx_ready;
    assign len_full_s    = {rx_data, len_r[7:0]};
    assign len_too_big_s = ({1'b0, len_full_s} > (17'd1 << INST_MEM_ADDR_SIZE));
    // len never exceeds 2**INST_MEM_ADDR_SIZE in DATA, so its low IDX_W bits are exact
    assign last_word_s   = (word_idx_r + IDX_W'(1)) == len_r[IDX_W-1:0];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-value logic for every registered signal
    always_comb begin
        state_nxt_s    = state_r;
        len_nxt_s      = len_r;
        word_nxt_s     = word_r;
        byte_cnt_nxt_s = byte_cnt_r;
        word_idx_nxt_s = word_idx_r;
        csum_nxt_s     = csum_r;
        inst_nxt_s     = inst;
        offset_nxt_s   = inst_mem_offset;
        dv_nxt_s       = 1'b0;
        done_nxt_s     = 1'b0;
        err_nxt_s      = load_error;

        case (state_r)
            IDLE: begin
                if (accept_s && (rx_data == SYNC_BYTE)) begin
                    state_nxt_s = LEN_LO;
                    csum_nxt_s  = 8'h00;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LEN_LO: begin
                if (accept_s) begin
                    len_nxt_s[7:0] = rx_data;
                    state_nxt_s    = LEN_HI;
                end else begin
                    state_nxt_s = LEN_LO;
                end
            end
            LEN_HI: begin
                if (accept_s) begin
                    len_nxt_s = len_full_s;
                    if (len_too_big_s) begin
                        state_nxt_s = ERROR;
                        err_nxt_s   = 1'b1;
                    end else if (len_full_s == 16'd0) begin
                        state_nxt_s = CHECK;
                    end else begin
                        state_nxt_s    = DATA;
                        word_idx_nxt_s = '0;
                        byte_cnt_nxt_s = 2'd0;
                    end
                end else begin
                    state_nxt_s = LEN_HI;
                end
            end
            DATA: begin
                if (accept_s) begin
                    word_nxt_s[{byte_cnt_r, 3'b000} +: 8] = rx_data;
                    csum_nxt_s     = csum_update(csum_r, rx_data);
                    byte_cnt_nxt_s = byte_cnt_r + 2'd1;
                    if (byte_cnt_r == 2'd3) begin
                        inst_nxt_s     = {rx_data, word_r[23:0]};
                        offset_nxt_s   = word_idx_r[INST_MEM_ADDR_SIZE-1:0];
                        dv_nxt_s       = 1'b1;
                        word_idx_nxt_s = word_idx_r + IDX_W'(1);
                        if (last_word_s) begin
                            state_nxt_s = CHECK;
                        end else begin
                            state_nxt_s = DATA;
                        end
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
            CHECK: begin
                if (accept_s) begin
                    if (rx_data == csum_r) begin
                        state_nxt_s = DONE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ERROR;
                        err_nxt_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = CHECK;
                end
            end
            DONE: begin
                state_nxt_s = DONE;
            end
            ERROR: begin
                state_nxt_s = ERROR;
                err_nxt_s   = 1'b1;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        ready_nxt_s = !((state_nxt_s == DONE) || (state_nxt_s == ERROR));
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_r                  <= 16'd0;
            word_r                 <= 32'd0;
            byte_cnt_r             <= 2'd0;
            word_idx_r             <= '0;
            csum_r                 <= 8'h00;
            inst                   <= 32'd0;
            inst_mem_offset        <= '0;
            programming_data_valid <= 1'b0;
            programming_done       <= 1'b0;
            load_error             <= 1'b0;
            rx_ready               <= 1'b1;
        end else begin
            len_r                  <= len_nxt_s;
            word_r                 <= word_nxt_s;
            byte_cnt_r             <= byte_cnt_nxt_s;
            word_idx_r             <= word_idx_nxt_s;
            csum_r                 <= csum_nxt_s;
            inst                   <= inst_nxt_s;
            inst_mem_offset        <= offset_nxt_s;
            programming_data_valid <= dv_nxt_s;
            programming_done       <= done_nxt_s;
            load_error             <= err_nxt_s;
            rx_ready               <= ready_nxt_s;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framed byte streams with hand-computed
// expected write pulses, checksum outcomes, length limits and mid-frame reset.
module tb_program_loader;

    logic        clk;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] inst;
    logic [9:0]  inst_mem_offset;
    logic        programming_data_valid;
    logic        programming_done;
    logic        load_error;

    int total = 0;
    int bad   = 0;

    logic [9:0]  dv_off_q[$];
    logic [31:0] dv_inst_q[$];
    int done_cnt  = 0;
    int both_cnt  = 0;
    int cyc       = 0;
    int last_dv_cyc = 0;
    int done_cyc  = 0;

    program_loader #(.INST_MEM_ADDR_SIZE(10), .SYNC_BYTE(8'hA5)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .rx_data                (rx_data),
        .rx_valid               (rx_valid),
        .rx_ready               (rx_ready),
        .inst                   (inst),
        .inst_mem_offset        (inst_mem_offset),
        .programming_data_valid (programming_data_valid),
        .programming_done       (programming_done),
        .load_error             (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every pulse seen on the programming port
    always @(negedge clk) begin
        if (programming_data_valid === 1'b1) begin
            dv_off_q.push_back(inst_mem_offset);
            dv_inst_q.push_back(inst);
            last_dv_cyc = cyc;
        end
        if (programming_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (programming_done === 1'b1 && load_error === 1'b1) both_cnt = both_cnt + 1;
    end

    task automatic apply_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Present one byte until accepted or the bound expires; acceptance is compared to exp_acc
    task automatic send_byte(input logic [7:0] b, input int gap, input bit exp_acc);
        bit acc;
        bit rdy;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            rdy = rx_ready;
            @(posedge clk);
            #1;
            if (rdy) acc = 1'b1;
        end
        rx_valid = 1'b0;
        total++;
        if (acc !== exp_acc) begin
            bad++;
            $display("FAIL byte_accept data=%02h got=%0d expected=%0d", b, acc, exp_acc);
        end
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({rx_ready, programming_data_valid, programming_done, load_error} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_flags got=%b expected=1000",
                     {rx_ready, programming_data_valid, programming_done, load_error});
        end
        total++;
        if (inst !== 32'd0 || inst_mem_offset !== 10'd0) begin
            bad++;
            $display("FAIL reset_data inst=%h off=%h expected 0/0", inst, inst_mem_offset);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_two_words();
        int base = dv_off_q.size();
        int d0   = done_cnt;
        apply_reset();
        send_byte(8'hA5, 0, 1'b1);
        send_byte(8'h02, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h13, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        @(negedge clk);
        total++;
        if (programming_data_valid !== 1'b1 || inst !== 32'h0000_0013 || rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL dv_latency dv=%b inst=%h rdy=%b expected 1/00000013/1",
                     programming_data_valid, inst, rx_ready);
        end
        @(posedge clk);
        #1;
        send_byte(8'h93, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h10, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h90, 0, 1'b1);
        settle();
        total++;
        if (dv_off_q.size() - base !== 2) begin
            bad++;
            $display("FAIL two_words_count got=%0d expected=2", dv_off_q.size() - base);
        end else begin
            total++;
            if (dv_off_q[base] !== 10'd0 || dv_inst_q[base] !== 32'h0000_0013) begin
                bad++;
                $display("FAIL word0 off=%h inst=%h expected 000/00000013", dv_off_q[base], dv_inst_q[base]);
            end
            total++;
            if (dv_off_q[base+1] !== 10'd1 || dv_inst_q[base+1] !== 32'h0010_0093) begin
                bad++;
                $display("FAIL word1 off=%h inst=%h expected 001/00100093", dv_off_q[base+1], dv_inst_q[base+1]);
            end
        end
        total++;
        if (done_cnt - d0 !== 1 || load_error !== 1'b0 || rx_ready !== 1'b0) begin
            bad++;
            $display("FAIL two_words_done done=%0d err=%b rdy=%b expected 1/0/0",
                     done_cnt - d0, load_error, rx_ready);
        end
        total++;
        if (done_cyc <= last_dv_cyc) begin
            bad++;
            $display("FAIL done_after_dv done_cyc=%0d dv_cyc=%0d expected done later", done_cyc, last_dv_cyc);
        end
        send_byte(8'hA5, 0, 1'b0);
    endtask

    task automatic test_garbage();
        int base = dv_off_q.size();
        int d0   = done_cnt;
        apply_reset();
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'hFF, 1, 1'b1);
        send_byte(8'h5A, 0, 1'b1);
        send_byte(8'hA5, 0, 1'b1);
        send_byte(8'h01, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h13, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h13, 0, 1'b1);
        settle();
        total++;
        if (dv_off_q.size() - base !== 1) begin
            bad++;
            $display("FAIL garbage_count got=%0d expected=1", dv_off_q.size() - base);
        end else begin
            total++;
            if (dv_off_q[base] !== 10'd0 || dv_inst_q[base] !== 32'h0000_0013) begin
                bad++;
                $display("FAIL garbage_word off=%h inst=%h expected 000/00000013", dv_off_q[base], dv_inst_q[base]);
            end
        end
        total++;
        if (done_cnt - d0 !== 1 || load_error !== 1'b0) begin
            bad++;
            $display("FAIL garbage_done done=%0d err=%b expected 1/0", done_cnt - d0, load_error);
        end
    endtask

    task automatic test_bad_csum();
        int base = dv_off_q.size();
        int d0   = done_cnt;
        apply_reset();
        send_byte(8'hA5, 0, 1'b1);
        send_byte(8'h01, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h13, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'hFF, 0, 1'b1);
        settle();
        total++;
        if (dv_off_q.size() - base !== 1 || done_cnt - d0 !== 0) begin
            bad++;
            $display("FAIL bad_csum_pulses dv=%0d done=%0d expected 1/0", dv_off_q.size() - base, done_cnt - d0);
        end
        total++;
        if (load_error !== 1'b1 || rx_ready !== 1'b0) begin
            bad++;
            $display("FAIL bad_csum_flags err=%b rdy=%b expected 1/0", load_error, rx_ready);
        end
        send_byte(8'hA5, 0, 1'b0);
    endtask

    task automatic test_len_too_big();
        int base = dv_off_q.size();
        int d0   = done_cnt;
        apply_reset();
        send_byte(8'hA5, 0, 1'b1);
        send_byte(8'h01, 0, 1'b1);
        send_byte(8'h04, 0, 1'b1);
        @(negedge clk);
        total++;
        if (load_error !== 1'b1 || rx_ready !== 1'b0) begin
            bad++;
            $display("FAIL len_big_flags err=%b rdy=%b expected 1/0", load_error, rx_ready);
        end
        @(posedge clk);
        #1;
        send_byte(8'h13, 0, 1'b0);
        total++;
        if (dv_off_q.size() - base !== 0 || done_cnt - d0 !== 0) begin
            bad++;
            $display("FAIL len_big_pulses dv=%0d done=%0d expected 0/0", dv_off_q.size() - base, done_cnt - d0);
        end
    endtask

    task automatic test_len_zero();
        int base = dv_off_q.size();
        int d0   = done_cnt;
        apply_reset();
        send_byte(8'hA5, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        settle();
        total++;
        if (dv_off_q.size() - base !== 0 || done_cnt - d0 !== 1 || load_error !== 1'b0) begin
            bad++;
            $display("FAIL len_zero dv=%0d done=%0d err=%b expected 0/1/0",
                     dv_off_q.size() - base, done_cnt - d0, load_error);
        end
    endtask

    task automatic test_mid_reset();
        int base;
        int d0;
        apply_reset();
        send_byte(8'hA5, 0, 1'b1);
        send_byte(8'h02, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h13, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        base = dv_off_q.size();
        d0   = done_cnt;
        apply_reset();
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        settle();
        total++;
        if (dv_off_q.size() - base !== 0 || done_cnt - d0 !== 0) begin
            bad++;
            $display("FAIL mid_reset_stale dv=%0d done=%0d expected 0/0", dv_off_q.size() - base, done_cnt - d0);
        end
        send_byte(8'hA5, 0, 1'b1);
        send_byte(8'h01, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h93, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h10, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h83, 0, 1'b1);
        settle();
        total++;
        if (dv_off_q.size() - base !== 1) begin
            bad++;
            $display("FAIL mid_reset_count got=%0d expected=1", dv_off_q.size() - base);
        end else begin
            total++;
            if (dv_off_q[base] !== 10'd0 || dv_inst_q[base] !== 32'h0010_0093) begin
                bad++;
                $display("FAIL mid_reset_word off=%h inst=%h expected 000/00100093", dv_off_q[base], dv_inst_q[base]);
            end
        end
        total++;
        if (done_cnt - d0 !== 1) begin
            bad++;
            $display("FAIL mid_reset_done got=%0d expected=1", done_cnt - d0);
        end
    endtask

    task automatic test_full_frame();
        int base = dv_off_q.size();
        int d0   = done_cnt;
        logic [31:0] w;
        logic [7:0]  cs;
        apply_reset();
        cs = 8'h00;
        send_byte(8'hA5, $urandom_range(0, 2), 1'b1);
        send_byte(8'h00, $urandom_range(0, 2), 1'b1);
        send_byte(8'h04, $urandom_range(0, 2), 1'b1);
        for (int i = 0; i < 1024; i++) begin
            w = (32'(i) * 32'h0001_0101) ^ 32'hA5A5_0000;
            for (int k = 0; k < 4; k++) begin
                cs = cs ^ w[8*k +: 8];
                send_byte(w[8*k +: 8], $urandom_range(0, 2), 1'b1);
            end
        end
        send_byte(cs, $urandom_range(0, 2), 1'b1);
        settle();
        total++;
        if (dv_off_q.size() - base !== 1024) begin
            bad++;
            $display("FAIL full_count got=%0d expected=1024", dv_off_q.size() - base);
        end else begin
            for (int i = 0; i < 1024; i++) begin
                w = (32'(i) * 32'h0001_0101) ^ 32'hA5A5_0000;
                total++;
                if (dv_off_q[base+i] !== 10'(i) || dv_inst_q[base+i] !== w) begin
                    bad++;
                    $display("FAIL full_word%0d off=%h inst=%h expected %h/%h",
                             i, dv_off_q[base+i], dv_inst_q[base+i], 10'(i), w);
                end
            end
        end
        total++;
        if (done_cnt - d0 !== 1 || load_error !== 1'b0 || inst_mem_offset !== 10'h3FF) begin
            bad++;
            $display("FAIL full_done done=%0d err=%b last_off=%h expected 1/0/3ff",
                     done_cnt - d0, load_error, inst_mem_offset);
        end
    endtask

    initial begin
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset_n  = 1'b0;
        test_reset();
        test_two_words();
        test_garbage();
        test_bad_csum();
        test_len_too_big();
        test_len_zero();
        test_mid_reset();
        test_full_frame();
        total++;
        if (both_cnt !== 0) begin
            bad++;
            $display("FAIL done_and_error got=%0d expected=0", both_cnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
